// File: rtl/eng_seq_cntl.sv
// Stripe sequencer for the parity engine: walks M bitmatrix columns per data word for cfg_len words.
// Optional build macro ENG_SEQ_CNTL_PERF_CNT_EN adds the perf_stall_cnt output.
module eng_seq_cntl #(
  parameter int M_W   = 3,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [M_W-1:0]   cfg_m,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             din_val,
  input  logic             bm_val,
  output logic             eng_rstn,
  output logic             eng_fsm_bm_cntl_rd_en,
  output logic             eng_bm_cntl_data_used,
  output logic             calc_en,
  output logic [M_W-1:0]   col_idx,
  output logic             din_pop,
  output logic             pout_val,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef ENG_SEQ_CNTL_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             abort_q, abort_d;
  logic [M_W-1:0]   col_cnt_q, col_cnt_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [M_W-1:0]   m_q, m_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             col_last, word_last;
  logic             start_ok;

  assign col_last  = (col_cnt_q == (m_q - M_W'(1)));
  assign word_last = (word_cnt_q == (len_q - LEN_W'(1)));
  assign start_ok  = (state_q == S_IDLE) && start && (cfg_m != '0) && (cfg_len != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      abort_q    <= 1'b0;
      col_cnt_q  <= '0;
      word_cnt_q <= '0;
      m_q        <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      abort_q    <= abort_d;
      col_cnt_q  <= col_cnt_d;
      word_cnt_q <= word_cnt_d;
      m_q        <= m_d;
      len_q      <= len_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    abort_d               = abort_q;
    col_cnt_d             = col_cnt_q;
    word_cnt_d            = word_cnt_q;
    m_d                   = m_q;
    len_d                 = len_q;
    err_d                 = 1'b0;
    eng_rstn              = 1'b1;
    eng_fsm_bm_cntl_rd_en = (state_q == S_WAIT) || (state_q == S_CALC);
    eng_bm_cntl_data_used = 1'b0;
    calc_en               = 1'b0;
    col_idx               = '0;
    din_pop               = 1'b0;
    pout_val              = 1'b0;
    busy                  = (state_q != S_IDLE);
    done                  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_d    = S_INIT;
            abort_d    = 1'b0;
            m_d        = cfg_m;
            len_d      = cfg_len;
            col_cnt_d  = '0;
            word_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // INIT doubles as the abort flush cycle; abort_q selects where it goes next
      S_INIT: begin
        eng_rstn = 1'b0;
        if (abort_q) begin
          state_d = S_IDLE;
          abort_d = 1'b0;
        end else if (abort) begin
          abort_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_INIT;
          abort_d = 1'b1;
        end else if (din_val && bm_val) begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (abort) begin
          state_d = S_INIT;
          abort_d = 1'b1;
        end else if (bm_val) begin
          calc_en               = 1'b1;
          eng_bm_cntl_data_used = 1'b1;
          col_idx               = col_cnt_q;
          if (col_last) begin
            din_pop    = 1'b1;
            pout_val   = 1'b1;
            col_cnt_d  = '0;
            word_cnt_d = word_cnt_q + LEN_W'(1);
            if (word_last)    state_d = S_DONE;
            else if (!din_val) state_d = S_WAIT;
          end else begin
            col_cnt_d = col_cnt_q + M_W'(1);
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_INIT;
          abort_d = 1'b1;
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err = err_q;

`ifdef ENG_SEQ_CNTL_PERF_CNT_EN
  logic [31:0] perf_q;
  logic        stall;

  // A WAIT cycle that is about to enter CALC is not counted as a stall
  assign stall = ((state_q == S_WAIT) && !(din_val && bm_val)) ||
                 ((state_q == S_CALC) && !bm_val);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= '0;
    end else if (stall && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_eng_seq_cntl.sv
// Directed bench for eng_seq_cntl; LEN_W shrunk to 4 so the all-ones stripe length stays short.
module tb_eng_seq_cntl;

  localparam int M_W   = 3;
  localparam int LEN_W = 4;

  // Packed output order: {eng_rstn, rd_en, data_used, calc_en, din_pop, pout_val, busy, done, err}
  localparam logic [8:0] O_IDLE  = 9'h100;
  localparam logic [8:0] O_ERR   = 9'h101;
  localparam logic [8:0] O_INIT  = 9'h004;
  localparam logic [8:0] O_WAIT  = 9'h184;
  localparam logic [8:0] O_COL   = 9'h1E4;
  localparam logic [8:0] O_LAST  = 9'h1FC;
  localparam logic [8:0] O_DONE  = 9'h106;

  logic             clk = 1'b0;
  logic             rstn, start, abort, din_val, bm_val;
  logic [M_W-1:0]   cfg_m;
  logic [LEN_W-1:0] cfg_len;
  logic             eng_rstn, rd_en, data_used, calc_en, din_pop, pout_val, busy, done, err;
  logic [M_W-1:0]   col_idx;
`ifdef ENG_SEQ_CNTL_PERF_CNT_EN
  logic [31:0]      perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eng_seq_cntl #(.M_W(M_W), .LEN_W(LEN_W)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .start                 (start),
    .abort                 (abort),
    .cfg_m                 (cfg_m),
    .cfg_len               (cfg_len),
    .din_val               (din_val),
    .bm_val                (bm_val),
    .eng_rstn              (eng_rstn),
    .eng_fsm_bm_cntl_rd_en (rd_en),
    .eng_bm_cntl_data_used (data_used),
    .calc_en               (calc_en),
    .col_idx               (col_idx),
    .din_pop               (din_pop),
    .pout_val              (pout_val),
    .busy                  (busy),
    .done                  (done),
    .err                   (err)
`ifdef ENG_SEQ_CNTL_PERF_CNT_EN
    ,
    .perf_stall_cnt        (perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s check did not match", tag);
    end
  endtask

  task automatic expect_outs(input string tag, input logic [8:0] e, input logic [M_W-1:0] ci);
    chk({tag, ".outs"}, 32'({eng_rstn, rd_en, data_used, calc_en, din_pop, pout_val, busy, done, err}),
        32'(e));
    chk({tag, ".col_idx"}, 32'(col_idx), 32'(ci));
  endtask

  // Inputs set before the call apply to this cycle; check mid-cycle, then move past the next edge
  task automatic stp(input string tag, input logic [8:0] e, input logic [M_W-1:0] ci);
    #1;
    expect_outs(tag, e, ci);
    $display("step %-14s outs=%03h col_idx=%0d", tag,
             {eng_rstn, rd_en, data_used, calc_en, din_pop, pout_val, busy, done, err}, col_idx);
    @(posedge clk);
    #1;
  endtask

  task automatic begin_stripe(input logic [M_W-1:0] m, input logic [LEN_W-1:0] len);
    cfg_m = m; cfg_len = len; start = 1'b1;
    stp("start", O_IDLE, 0);
    start = 1'b0;
    stp("init", O_INIT, 0);
    stp("wait", O_WAIT, 0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; din_val = 1'b0; bm_val = 1'b0;
    cfg_m = '0; cfg_len = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_outs("reset", O_IDLE, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;

    // Two words of three columns, inputs always ready
    din_val = 1'b1; bm_val = 1'b1;
    begin_stripe(3'd3, 4'd2);
    stp("w0c0", O_COL, 0);
    stp("w0c1", O_COL, 1);
    stp("w0c2", O_LAST, 2);
    stp("w1c0", O_COL, 0);
    stp("w1c1", O_COL, 1);
    stp("w1c2", O_LAST, 2);
    stp("done", O_DONE, 0);
    stp("idle", O_IDLE, 0);

    // bm_val stall after the first column
    begin_stripe(3'd2, 4'd1);
    stp("s_c0", O_COL, 0);
    bm_val = 1'b0;
    stp("s_stall0", O_WAIT, 0);
    stp("s_stall1", O_WAIT, 0);
    bm_val = 1'b1;
    stp("s_c1", O_LAST, 1);
    stp("s_done", O_DONE, 0);
`ifdef ENG_SEQ_CNTL_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, 32'd2);
`endif
    stp("s_idle", O_IDLE, 0);

    // Rejected starts: zero columns, then zero length
    cfg_m = 3'd0; cfg_len = 4'd5; start = 1'b1;
    stp("e0_start", O_IDLE, 0);
    start = 1'b0;
    stp("e0_err", O_ERR, 0);
    stp("e0_idle", O_IDLE, 0);
    cfg_m = 3'd3; cfg_len = 4'd0; start = 1'b1;
    stp("e1_start", O_IDLE, 0);
    start = 1'b0;
    stp("e1_err", O_ERR, 0);
    stp("e1_idle", O_IDLE, 0);

    // Abort in IDLE does nothing
    abort = 1'b1;
    stp("ia_idle", O_IDLE, 0);
    abort = 1'b0;
    stp("ia_after", O_IDLE, 0);

    // Abort on the column-1 cycle suppresses all CALC outputs
    begin_stripe(3'd3, 4'd2);
    stp("a_c0", O_COL, 0);
    abort = 1'b1;
    stp("a_c1", O_WAIT, 0);
    abort = 1'b0;
    stp("a_flush", O_INIT, 0);
    stp("a_idle0", O_IDLE, 0);
    stp("a_idle1", O_IDLE, 0);

    // start during CALC with an invalid config is ignored
    begin_stripe(3'd2, 4'd1);
    cfg_m = 3'd0; start = 1'b1;
    stp("b_c0", O_COL, 0);
    start = 1'b0;
    stp("b_c1", O_LAST, 1);
    stp("b_done", O_DONE, 0);
    stp("b_idle", O_IDLE, 0);

    // rstn mid-CALC: outputs drop immediately, no done afterwards
    begin_stripe(3'd3, 4'd2);
    stp("r_c0", O_COL, 0);
    rstn = 1'b0;
    #1;
    expect_outs("r_async", O_IDLE, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    stp("r_idle0", O_IDLE, 0);
    stp("r_idle1", O_IDLE, 0);

    // Word boundary with din_val low returns to WAIT
    begin_stripe(3'd1, 4'd2);
    din_val = 1'b0;
    stp("g_w0", O_LAST, 0);
    stp("g_wait", O_WAIT, 0);
    din_val = 1'b1;
    stp("g_wait2", O_WAIT, 0);
    stp("g_w1", O_LAST, 0);
    stp("g_done", O_DONE, 0);

    // M=1 with the all-ones stripe length
    begin_stripe(3'd1, 4'd15);
    for (int i = 0; i < 15; i++) stp("max_word", O_LAST, 0);
    stp("max_done", O_DONE, 0);
    stp("max_idle", O_IDLE, 0);

    // Widest column count
    begin_stripe(3'd7, 4'd1);
    for (int i = 0; i < 6; i++) stp("m7_col", O_COL, 3'(i));
    stp("m7_last", O_LAST, 3'd6);
    stp("m7_done", O_DONE, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
